// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, state type and address helper for the framebuffer arbiter
package fb_pkg;
  localparam int DATA_WIDTH   = 8;
  localparam int MEM_DEPTH    = 76800;
  localparam int ADDR_WIDTH   = 17;
  localparam int STARVE_WIDTH = 3;

  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX   = 3'd4;
  localparam logic [ADDR_WIDTH-1:0]   FB_LAST_ADDR = 17'd76799;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, CLEAR} fb_state_t;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == FB_LAST_ADDR) ? '0 : a + 17'd1;
  endfunction
endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - single-port pixel RAM, registered read with one cycle of latency
module fb_ram
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= data_in;
    data_out_q <= mem[addr];
  end

  assign data_out = data_out_q;
endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - framebuffer access arbiter: scan-out reads, writer port, starvation guard
// Optional full-frame clear engine built when FB_CLEAR_EN is defined.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_start,
  input  logic                  scan_req,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_err,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_color,
  output logic                  clr_busy
);
  fb_state_t               state_d, state_q;
  logic [ADDR_WIDTH-1:0]   scan_addr_d, scan_addr_q, scan_rd_addr;
  logic                    scan_stall_d, scan_stall_q;
  logic [STARVE_WIDTH-1:0] starve_cnt_d, starve_cnt_q;
  logic                    pix_valid_d, pix_valid_q;
  logic                    wr_ack_d, wr_ack_q, wr_err_d, wr_err_q;
  logic                    scan_pend, wr_forced, wr_in_range;
  logic                    clr_pend;
  logic [ADDR_WIDTH-1:0]   clr_wr_addr;
  logic [DATA_WIDTH-1:0]   clr_wr_data;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;

  always_comb begin
    scan_pend    = scan_req | scan_stall_q;
    wr_forced    = wr_req && (starve_cnt_q == STARVE_MAX);
    wr_in_range  = (wr_addr <= FB_LAST_ADDR);
    scan_rd_addr = scan_start ? '0 : scan_addr_q;

    if (wr_forced)      state_d = WRITE;
    else if (scan_pend) state_d = SCAN;
    else if (clr_pend)  state_d = CLEAR;
    else if (wr_req)    state_d = WRITE;
    else                state_d = IDLE;

    // A scan request displaced by a forced write is remembered for one cycle
    scan_stall_d = scan_pend && wr_forced;
    scan_addr_d  = (state_d == SCAN) ? next_addr(scan_rd_addr) : scan_rd_addr;

    if (!wr_req || state_d == WRITE)  starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 3'd1;
    else                               starve_cnt_d = starve_cnt_q;

    pix_valid_d = (state_d == SCAN);
    wr_ack_d    = (state_d == WRITE);
    wr_err_d    = (state_d == WRITE) && !wr_in_range;

    // Reset blocks the RAM write so an aborted grant leaves memory untouched
    ram_we    = !rst && (((state_d == WRITE) && wr_in_range) || (state_d == CLEAR));
    ram_addr  = scan_rd_addr;
    ram_wdata = wr_data;
    if (state_d == WRITE && wr_in_range) begin
      ram_addr = wr_addr;
    end else if (state_d == CLEAR) begin
      ram_addr  = clr_wr_addr;
      ram_wdata = clr_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scan_addr_q  <= '0;
      scan_stall_q <= 1'b0;
      starve_cnt_q <= '0;
      pix_valid_q  <= 1'b0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      scan_stall_q <= scan_stall_d;
      starve_cnt_q <= starve_cnt_d;
      pix_valid_q  <= pix_valid_d;
      wr_ack_q     <= wr_ack_d;
      wr_err_q     <= wr_err_d;
    end
  end

`ifdef FB_CLEAR_EN
  logic                  clr_busy_d, clr_busy_q;
  logic [ADDR_WIDTH-1:0] clr_addr_d, clr_addr_q;
  logic [DATA_WIDTH-1:0] clr_color_d, clr_color_q;

  always_comb begin
    clr_busy_d  = clr_busy_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    if (state_d == CLEAR) begin
      clr_addr_d = next_addr(clr_addr_q);
      if (clr_addr_q == FB_LAST_ADDR) clr_busy_d = 1'b0;
    end else if (clr_start && !clr_busy_q) begin
      clr_busy_d  = 1'b1;
      clr_addr_d  = '0;
      clr_color_d = clr_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_busy_q  <= 1'b0;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else begin
      clr_busy_q  <= clr_busy_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
    end
  end

  assign clr_pend    = clr_busy_q;
  assign clr_busy    = clr_busy_q;
  assign clr_wr_addr = clr_addr_q;
  assign clr_wr_data = clr_color_q;
`else
  logic unused_clr;
  assign unused_clr  = ^{clr_start, clr_color};
  assign clr_pend    = 1'b0;
  assign clr_busy    = 1'b0;
  assign clr_wr_addr = '0;
  assign clr_wr_data = '0;
`endif

  fb_ram u_ram (
    .clk      (clk),
    .wr_en    (ram_we),
    .addr     (ram_addr),
    .data_in  (ram_wdata),
    .data_out (ram_rdata)
  );

  assign pix_data  = (state_q == SCAN) ? ram_rdata : '0;
  assign pix_valid = pix_valid_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard testbench for fb_arbiter (clear tests follow FB_CLEAR_EN)
`timescale 1ns/1ps
module tb_fb_arbiter;
  logic        clk = 1'b0;
  logic        rst, scan_start, scan_req, wr_req, clr_start;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data, clr_color, pix_data;
  logic        pix_valid, wr_ack, wr_err, clr_busy;

  fb_arbiter dut (
    .clk(clk), .rst(rst), .scan_start(scan_start), .scan_req(scan_req),
    .pix_data(pix_data), .pix_valid(pix_valid), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .clr_start(clr_start),
    .clr_color(clr_color), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        known;
    int          addr;
    logic [7:0]  val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [0:76799];
  bit         model_known [0:76799];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 0;
  int         pix_cnt = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  logic [7:0] last_pix = 8'h00;
  int         bench_addr = 0;

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every valid pixel is matched against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && pix_valid === 1'b1) begin
      if (pix_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      pix_cnt++;
      last_pix = pix_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scan_unexpected got pixel %h required no pixel", pix_data);
      end else begin
        e = exp_q.pop_front();
        if (e.known) begin
          checks++;
          if (pix_data !== e.val) begin
            errors++;
            $display("FAIL scan_data addr %0d got %h required %h", e.addr, pix_data, e.val);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan();
    exp_t e;
    e.known = model_known[bench_addr];
    e.addr  = bench_addr;
    e.val   = model[bench_addr];
    exp_q.push_back(e);
    bench_addr = (bench_addr == 76799) ? 0 : bench_addr + 1;
  endtask

  task automatic scan_burst(input bit start, input int n);
    pix_cnt = 0;
    if (start) bench_addr = 0;
    for (int i = 0; i < n; i++) begin
      scan_start = start && (i == 0);
      scan_req   = 1'b1;
      push_scan();
      tick();
    end
    scan_start = 1'b0;
    scan_req   = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_write(input logic [16:0] a, input logic [7:0] d, output int lat, output logic err);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    lat     = 0;
    err     = 1'b0;
    while (lat < 20) begin
      tick();
      lat++;
      if (wr_ack === 1'b1) break;
    end
    err    = wr_err;
    wr_req = 1'b0;
    if (a < 17'd76800) begin
      model[a]       = d;
      model_known[a] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({pix_valid, pix_data, wr_ack, wr_err, clr_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {pix_valid, pix_data, wr_ack, wr_err, clr_busy});
    end
    rst = 1'b0;
    tick();
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int busy_cycles;
    clr_color = 8'h3C;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    clr_color = 8'h00;
    busy_cycles = 0;
    while (clr_busy === 1'b1 && busy_cycles < 80000) begin
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 76800) begin
      errors++;
      $display("FAIL clear_busy_len got %0d required 76800", busy_cycles);
    end
    for (int i = 0; i < 76800; i++) begin
      model[i]       = 8'h3C;
      model_known[i] = 1'b1;
    end
  endtask
`else
  task automatic test_no_clear();
    clr_color = 8'h3C;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_clear_busy got %b required 0", clr_busy);
    end
  endtask
`endif

  task automatic test_write_read();
    int   lat;
    logic err;
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 7 + 3);
      do_write(17'(i), v, lat, err);
      checks++;
      if (lat != 1 || err !== 1'b0) begin
        errors++;
        $display("FAIL write_ack addr %0d got lat %0d err %b required lat 1 err 0", i, lat, err);
      end
    end
    do_write(17'd100, 8'hA5, lat, err);
    checks++;
    if (lat != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_100 got lat %0d err %b required lat 1 err 0", lat, err);
    end
    do_write(17'd76799, 8'hEE, lat, err);
    checks++;
    if (lat != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_last got lat %0d err %b required lat 1 err 0", lat, err);
    end
    mon_en = 1'b1;
    scan_burst(1'b1, 101);
    checks++;
    if (pix_cnt != 101 || last_pix !== 8'hA5) begin
      errors++;
      $display("FAIL read_101 got count %0d pixel %h required count 101 pixel a5", pix_cnt, last_pix);
    end
  endtask

  task automatic test_reset_mid_scan();
    scan_start = 1'b1;
    scan_req   = 1'b1;
    bench_addr = 0;
    push_scan();
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_scan();
      tick();
    end
    mon_en   = 1'b0;
    rst      = 1'b1;
    scan_req = 1'b0;
    wr_req   = 1'b1;
    wr_addr  = 17'd7;
    wr_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pix_valid, pix_data, wr_ack, wr_err, clr_busy} !== 12'h000) begin
        errors++;
        $display("FAIL mid_reset_outputs cycle %0d got %b required 0", i, {pix_valid, pix_data, wr_ack, wr_err, clr_busy});
      end
    end
    rst    = 1'b0;
    wr_req = 1'b0;
    exp_q.delete();
    tick();
    mon_en     = 1'b1;
    bench_addr = 0;
    scan_burst(1'b0, 1);
    checks++;
    if (pix_cnt != 1 || last_pix !== 8'h03) begin
      errors++;
      $display("FAIL reset_scan_addr0 got count %0d pixel %h required count 1 pixel 03", pix_cnt, last_pix);
    end
  endtask

  task automatic test_error();
    int   lat;
    logic err;
    do_write(17'd0, 8'h5A, lat, err);
    checks++;
    if (lat != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_addr0 got lat %0d err %b required lat 1 err 0", lat, err);
    end
    do_write(17'd76800, 8'h77, lat, err);
    checks++;
    if (lat != 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL write_oob got lat %0d err %b required lat 1 err 1", lat, err);
    end
    scan_burst(1'b1, 1);
    checks++;
    if (pix_cnt != 1 || last_pix !== 8'h5A) begin
      errors++;
      $display("FAIL oob_no_write got count %0d pixel %h required count 1 pixel 5a", pix_cnt, last_pix);
    end
  endtask

  task automatic test_starvation();
    int ack_lat;
    ack_lat    = -1;
    pix_cnt    = 0;
    bench_addr = 0;
    scan_start = 1'b1;
    scan_req   = 1'b1;
    wr_req     = 1'b1;
    wr_addr    = 17'd5000;
    wr_data    = 8'hC7;
    for (int i = 0; i < 10; i++) begin
      push_scan();
      tick();
      scan_start = 1'b0;
      if (wr_req && wr_ack === 1'b1) begin
        ack_lat            = i + 1;
        wr_req             = 1'b0;
        model[5000]        = 8'hC7;
        model_known[5000]  = 1'b1;
      end
    end
    wr_req   = 1'b0;
    scan_req = 1'b0;
    tick();
    tick();
    checks++;
    if (ack_lat < 1 || ack_lat > 6) begin
      errors++;
      $display("FAIL starve_ack got latency %0d required 1..6", ack_lat);
    end
    checks++;
    if (pix_cnt != 9) begin
      errors++;
      $display("FAIL starve_pix_count got %0d required 9", pix_cnt);
    end
    checks++;
    if (last_cyc - first_cyc + 1 != 10) begin
      errors++;
      $display("FAIL starve_gap got span %0d required 10", last_cyc - first_cyc + 1);
    end
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL starve_leftover got %0d required 1", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    scan_burst(1'b1, 76801);
    checks++;
    if (pix_cnt != 76801) begin
      errors++;
      $display("FAIL wrap_count got %0d required 76801", pix_cnt);
    end
    checks++;
    if (last_cyc - first_cyc + 1 != 76801) begin
      errors++;
      $display("FAIL wrap_gapless got span %0d required 76801", last_cyc - first_cyc + 1);
    end
    checks++;
    if (last_pix !== 8'h5A) begin
      errors++;
      $display("FAIL wrap_addr0 got %h required 5a", last_pix);
    end
  endtask

  initial begin
    rst        = 1'b1;
    scan_start = 1'b0;
    scan_req   = 1'b0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    clr_start  = 1'b0;
    clr_color  = '0;
    for (int i = 0; i < 76800; i++) begin
      model[i]       = 8'h00;
      model_known[i] = 1'b0;
    end
    test_reset();
`ifdef FB_CLEAR_EN
    test_clear();
`else
    test_no_clear();
`endif
    test_write_read();
    test_reset_mid_scan();
    test_error();
    test_starvation();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end
endmodule
